// File: rtl/wb_fabric_pkg.sv
// Shared types and constants for the single-master Wishbone fabric.
// Holds the FSM encoding, the default error read data and the slave-count limit.
package wb_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADB_AD00;
    localparam int          MAX_SLAVES       = 8;

    // Slave-select field width; one bit even for a single slave so index 1 can be flagged.
    function automatic int sel_width(input int n);
        int n_lim;
        n_lim = (n > MAX_SLAVES) ? MAX_SLAVES : n;
        return (n_lim <= 1) ? 1 : $clog2(n_lim);
    endfunction

endpackage

// File: rtl/wb_fabric_timeout.sv
// Busy-cycle watchdog: cleared on load, counts while enabled, flags the last allowed cycle.
// Expiry is combinational so the FSM can still let a same-cycle slave ack win.
module wb_fabric_timeout
    import wb_fabric_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/wb_fabric.sv
// Single-master to NUM_SLAVES Wishbone decoder with one outstanding transfer,
// registered master ack, unmapped/timeout error responses and a saturating error count.
module wb_fabric
    import wb_fabric_pkg::*;
#(
    parameter int          NUM_SLAVES  = 4,
    parameter int          SLV_ADR_W   = 9,
    parameter int          SEL_LSB     = 10,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    m_wb_cyc_i,
    input  logic                    m_wb_stb_i,
    input  logic                    m_wb_we_i,
    input  logic [31:0]             m_wb_adr_i,
    input  logic [31:0]             m_wb_dat_i,
    input  logic [3:0]              m_wb_sel_i,
    output logic                    m_wb_ack_o,
    output logic [31:0]             m_wb_dat_o,
    output logic                    m_wb_err_o,
    output logic [NUM_SLAVES-1:0]   s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]   s_wb_stb_o,
    output logic [NUM_SLAVES-1:0]   s_wb_we_o,
    output logic [SLV_ADR_W-1:0]    s_wb_adr_o,
    output logic [31:0]             s_wb_dat_o,
    output logic [3:0]              s_wb_sel_o,
    input  logic [32*NUM_SLAVES-1:0] s_wb_dat_i,
    input  logic [NUM_SLAVES-1:0]   s_wb_ack_i,
    output logic [7:0]              err_cnt_o
);

    localparam int             SEL_W     = sel_width(NUM_SLAVES);
    localparam logic [SEL_W:0] SLV_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

    state_t               r_state, w_next;
    logic [SEL_W-1:0]     r_index;
    logic [SLV_ADR_W-1:0] r_adr;
    logic [31:0]          r_dat, r_mdat;
    logic [3:0]           r_sel;
    logic                 r_we, r_ack, r_err;
    logic [7:0]           r_err_cnt;

    logic [SEL_W-1:0] w_index;
    logic             w_req, w_mapped, w_busy, w_load, w_expire, w_slv_ack;
    logic [31:0]      w_slv_dat;
    logic             w_unused;

    assign w_req    = m_wb_cyc_i & m_wb_stb_i;
    assign w_index  = m_wb_adr_i[SEL_LSB +: SEL_W];
    assign w_mapped = ({1'b0, w_index} < SLV_LIMIT);
    assign w_busy   = (r_state == ST_BUSY);
    assign w_load   = (r_state == ST_IDLE) && w_req;
    assign w_unused = ^m_wb_adr_i;

    // NOTE: every combinational output gets a default before the loop/case, so no latch is inferred.
    always_comb begin
        w_slv_dat  = '0;
        w_slv_ack  = 1'b0;
        s_wb_cyc_o = '0;
        s_wb_we_o  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_index == SEL_W'(i)) begin
                w_slv_dat     = s_wb_dat_i[i*32 +: 32];
                w_slv_ack     = s_wb_ack_i[i];
                s_wb_cyc_o[i] = w_busy;
                s_wb_we_o[i]  = w_busy & r_we;
            end
        end
    end

    assign s_wb_stb_o = s_wb_cyc_o;

    wb_fabric_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_load  (w_load),
        .i_en    (w_busy),
        .o_expire(w_expire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // A master abort outranks a slave ack, and a slave ack outranks the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = w_mapped ? ST_BUSY : ST_ERR;
            ST_BUSY: begin
                if (!m_wb_cyc_i)    w_next = ST_IDLE;
                else if (w_slv_ack) w_next = ST_RESP;
                else if (w_expire)  w_next = ST_ERR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_index   <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_we      <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_mdat    <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_load) begin
                r_index <= w_index;
                r_adr   <= m_wb_adr_i[SLV_ADR_W+1:2];
                r_dat   <= m_wb_dat_i;
                r_sel   <= m_wb_sel_i;
                r_we    <= m_wb_we_i;
            end
            r_ack <= (w_next == ST_RESP) || (w_next == ST_ERR);
            r_err <= (w_next == ST_ERR);
            case (w_next)
                ST_RESP: r_mdat <= w_slv_dat;
                ST_ERR:  r_mdat <= ERR_DATA;
                default: r_mdat <= '0;
            endcase
            if ((w_next == ST_ERR) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign m_wb_ack_o = r_ack;
    assign m_wb_err_o = r_err;
    assign m_wb_dat_o = r_mdat;
    assign s_wb_adr_o = r_adr;
    assign s_wb_dat_o = r_dat;
    assign s_wb_sel_o = r_sel;
    assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_wb_fabric.sv
// Self-checking bench for wb_fabric: table of transfers with a response scoreboard,
// plus directed master-abort, mid-transfer reset and error-count saturation sequences.
module tb_wb_fabric;

    localparam int NS = 3;
    localparam int TO = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                cyc, stb, we;
    logic [31:0]         adr, wdat;
    logic [3:0]          sel;
    logic                m_ack, m_err;
    logic [31:0]         m_dat;
    logic [NS-1:0]       s_cyc, s_stb, s_we;
    logic [8:0]          s_adr;
    logic [31:0]         s_dat;
    logic [3:0]          s_sel;
    logic [32*NS-1:0]    s_rdat;
    logic [NS-1:0]       s_ack;
    logic [7:0]          err_cnt;

    always #5 clk = ~clk;

    wb_fabric #(
        .NUM_SLAVES (NS),
        .SLV_ADR_W  (9),
        .SEL_LSB    (10),
        .TIMEOUT_CYC(TO),
        .ERR_DATA   (32'hBADB_AD00)
    ) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m_wb_cyc_i(cyc),
        .m_wb_stb_i(stb),
        .m_wb_we_i (we),
        .m_wb_adr_i(adr),
        .m_wb_dat_i(wdat),
        .m_wb_sel_i(sel),
        .m_wb_ack_o(m_ack),
        .m_wb_dat_o(m_dat),
        .m_wb_err_o(m_err),
        .s_wb_cyc_o(s_cyc),
        .s_wb_stb_o(s_stb),
        .s_wb_we_o (s_we),
        .s_wb_adr_o(s_adr),
        .s_wb_dat_o(s_dat),
        .s_wb_sel_o(s_sel),
        .s_wb_dat_i(s_rdat),
        .s_wb_ack_i(s_ack),
        .err_cnt_o (err_cnt)
    );

    // wait_cyc: slave acks in BUSY cycle wait_cyc+1; -1 means it never acks.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        int          wait_cyc;
        logic [31:0] rdat;
        logic        noise;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ack"},     32'(m_ack),   32'd0);
        check({tag, " err"},     32'(m_err),   32'd0);
        check({tag, " mdat"},    m_dat,        32'd0);
        check({tag, " cyc"},     32'(s_cyc),   32'd0);
        check({tag, " stb"},     32'(s_stb),   32'd0);
        check({tag, " we"},      32'(s_we),    32'd0);
        check({tag, " sadr"},    32'(s_adr),   32'd0);
        check({tag, " sdat"},    s_dat,        32'd0);
        check({tag, " ssel"},    32'(s_sel),   32'd0);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        exp_t          e;
        logic [1:0]    idx;
        logic [NS-1:0] oh;
        logic [8:0]    exp_adr;
        logic [31:0]   adr_v;
        bit            done;
        done    = 1'b0;
        adr_v   = v.adr;
        idx     = adr_v[11:10];
        exp_adr = adr_v[10:2];
        for (int i = 0; i < NS; i++) oh[i] = (int'(idx) == i);

        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = v.we;
        adr  = v.adr;
        wdat = v.wdat;
        sel  = v.sel;
        for (int i = 0; i < NS; i++) s_rdat[i*32 +: 32] = oh[i] ? v.rdat : (32'hDEAD_0000 | 32'(i));
        s_ack = '0;
        sb_q.push_back('{v.exp_err, v.exp_dat, v.exp_lat});

        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (m_ack) begin
                e = sb_q.pop_front();
                check({tag, " lat"},      32'(k),     32'(e.lat));
                check({tag, " err"},      32'(m_err), 32'(e.err));
                check({tag, " mdat"},     m_dat,      e.dat);
                check({tag, " stb_ack"},  32'(s_stb), 32'd0);
                done = 1'b1;
            end else begin
                check({tag, " busy_stb"}, 32'(s_stb), 32'(oh));
                check({tag, " busy_cyc"}, 32'(s_cyc), 32'(oh));
                check({tag, " busy_we"},  32'(s_we),  v.we ? 32'(oh) : 32'd0);
                check({tag, " busy_adr"}, 32'(s_adr), 32'(exp_adr));
                check({tag, " busy_dat"}, s_dat,      v.wdat);
                check({tag, " busy_sel"}, 32'(s_sel), 32'(v.sel));
                s_ack = v.noise ? ~oh : '0;
                if (v.wait_cyc >= 0 && k == v.wait_cyc + 1) s_ack = s_ack | oh;
            end
        end
        check({tag, " ack_seen"}, 32'(done), 32'd1);
        if (!done && sb_q.size() > 0) void'(sb_q.pop_front());

        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        s_ack = '0;
        if (v.exp_err && exp_err_cnt != 255) exp_err_cnt++;
        @(negedge clk);
        check({tag, " ack_pulse"}, 32'(m_ack),   32'd0);
        check({tag, " mdat_idle"}, m_dat,        32'd0);
        check({tag, " err_cnt"},   32'(err_cnt), 32'(exp_err_cnt));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t unm;
        vecs[0] = '{1'b1, 32'h0000_0808, 32'h1234_5678, 4'hF,  0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 2};
        vecs[1] = '{1'b0, 32'h0000_0404, 32'h0000_0000, 4'hF,  3, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 5};
        vecs[2] = '{1'b0, 32'h0000_0C00, 32'h0000_0000, 4'hF,  0, 32'h0000_0000, 1'b0, 1'b1, 32'hBADB_AD00, 1};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, -1, 32'h1111_2222, 1'b0, 1'b1, 32'hBADB_AD00, 5};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF,  3, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'hA5A5_5A5A, 5};
        vecs[5] = '{1'b1, 32'h0000_04FC, 32'h0F0F_0F0F, 4'h3,  1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 3};
        vecs[6] = '{1'b0, 32'h0000_080C, 32'h0000_0000, 4'hF,  2, 32'h1357_9BDF, 1'b1, 1'b0, 32'h1357_9BDF, 4};
        vecs[7] = '{1'b1, 32'h0000_0F00, 32'hFFFF_FFFF, 4'hF,  0, 32'h0000_0000, 1'b0, 1'b1, 32'hBADB_AD00, 1};
        unm     = '{1'b0, 32'h0000_0C00, 32'h0000_0000, 4'hF,  0, 32'h0000_0000, 1'b0, 1'b1, 32'hBADB_AD00, 1};

        rst    = 1'b1;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        adr    = '0;
        wdat   = '0;
        sel    = '0;
        s_rdat = '0;
        s_ack  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Master drops cyc in BUSY; a late slave ack must not produce a master ack.
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b0;
        adr  = 32'h0000_0404;
        s_rdat[32 +: 32] = 32'h1111_1111;
        @(negedge clk);
        check("drop busy_stb", 32'(s_stb), 32'b010);
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);
        check("drop stb",  32'(s_stb), 32'd0);
        check("drop cyc",  32'(s_cyc), 32'd0);
        check("drop ack",  32'(m_ack), 32'd0);
        s_ack = 3'b010;
        @(negedge clk);
        s_ack = '0;
        check("drop ack_late", 32'(m_ack),   32'd0);
        check("drop err_cnt",  32'(err_cnt), 32'(exp_err_cnt));

        // Reset while a write is in BUSY.
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        adr  = 32'h0000_0808;
        wdat = 32'h55AA_55AA;
        sel  = 4'hC;
        @(negedge clk);
        check("rstbusy stb", 32'(s_stb), 32'b100);
        check("rstbusy we",  32'(s_we),  32'b100);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rstbusy");
        rst = 1'b0;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        exp_err_cnt = 0;
        @(negedge clk);
        check("rstbusy ack_after", 32'(m_ack), 32'd0);

        for (int i = 0; i < 300; i++) do_txn(unm, "sat");
        check("sat final", 32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_fabric.md
WB_FABRIC -- requirements
Module: wb_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal 1..8).
REQ-002 SHALL have parameter SLV_ADR_W, default 9, address width forwarded to each slave (word-indexed, from m_wb_adr_i[SLV_ADR_W+1:2]).
REQ-003 SHALL have parameter SEL_LSB, default 10, lowest master address bit of the slave-select field (width SEL_W = max(1, clog2(NUM_SLAVES))).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 255, maximum BUSY cycles before a forced error response (legal 1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hBADB_AD00, read data returned on any error response.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 wb_clk_i  in  1  system clock, all state on rising edge.
REQ-008 wb_rst_i  in  1  synchronous active-high reset.
REQ-009 m_wb_cyc_i, m_wb_stb_i, m_wb_we_i  in  1 each  master cycle, strobe, write enable.
REQ-010 m_wb_adr_i  in  32  master byte address; m_wb_dat_i  in  32  write data; m_wb_sel_i  in  4  byte enables.
REQ-011 m_wb_ack_o  out  1  master acknowledge; m_wb_dat_o  out  32  read data; m_wb_err_o  out  1  error qualifier, high only together with m_wb_ack_o.
REQ-012 s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  NUM_SLAVES each  per-slave controls, bit i = slave i.
REQ-013 s_wb_adr_o  out  SLV_ADR_W, s_wb_dat_o  out  32, s_wb_sel_o  out  4  shared slave buses.
REQ-014 s_wb_dat_i  in  32*NUM_SLAVES  flattened read data, slice i = slave i; s_wb_ack_i  in  NUM_SLAVES  per-slave acks.
REQ-015 err_cnt_o  out  8  saturating count of error responses.

Function
REQ-016 SHALL implement FSM IDLE, BUSY, RESP, ERR.
REQ-017 IDLE: on m_wb_cyc_i & m_wb_stb_i SHALL register adr/dat/sel/we and index = m_wb_adr_i[SEL_LSB+SEL_W-1:SEL_LSB]; index < NUM_SLAVES -> BUSY, else -> ERR.
REQ-018 BUSY: SHALL assert s_wb_cyc_o[index] and s_wb_stb_o[index] only, s_wb_we_o[index] = registered we, all other slave bits 0.
REQ-019 BUSY: on s_wb_ack_i[index] SHALL capture s_wb_dat_i slice index, deassert slave cyc/stb next cycle, go RESP; acks from non-selected slaves SHALL be ignored.
REQ-020 BUSY: timeout counter SHALL reset to 0 on BUSY entry and increment each BUSY cycle; reaching TIMEOUT_CYC without ack -> ERR; ack in same cycle as expiry -> RESP (ack wins).
REQ-021 RESP: m_wb_ack_o=1, m_wb_err_o=0, m_wb_dat_o=captured data, exactly one cycle, then IDLE.
REQ-022 ERR: m_wb_ack_o=1, m_wb_err_o=1, m_wb_dat_o=ERR_DATA, exactly one cycle, then IDLE; err_cnt_o +1, saturating at 255.
REQ-023 m_wb_ack_o SHALL be registered; minimum latency request-sample to ack = 2 cycles (slave acking in first BUSY cycle); unmapped access = 1 cycle.
REQ-024 m_wb_cyc_i falling in BUSY SHALL drop slave cyc/stb next cycle and return to IDLE with no master ack and no err_cnt change.
REQ-025 m_wb_dat_o SHALL be 0 outside RESP/ERR; s_wb_adr_o/dat/sel hold last registered values.
REQ-026 NUM_SLAVES=1: slave-select field still decoded; index 1 -> ERR.

Reset
REQ-027 wb_rst_i SHALL force IDLE, all s_wb_cyc_o/s_wb_stb_o/s_wb_we_o=0, m_wb_ack_o=0, m_wb_err_o=0, m_wb_dat_o=0, timeout counter=0, err_cnt_o=0, registered adr/dat/sel=0.
REQ-028 Reset in BUSY SHALL abandon the transfer at the next edge with no master ack.

Structure
REQ-029 Package wb_fabric_pkg SHALL hold FSM state encoding, ERR_DATA default and max-slave constant 8.
REQ-030 Sub-module wb_fabric_timeout (load/enable/expire counter, width clog2(TIMEOUT_CYC+1)) SHALL implement REQ-020.

Verification
REQ-031 NUM_SLAVES=4, write 0x1234_5678 to adr 0x0000_0808, slave 2 acks in 1st BUSY cycle -> s_wb_stb_o=4'b0100, s_wb_adr_o=9'h002, m_wb_ack_o 2 cycles after request, err=0.
REQ-032 Read adr 0x0000_0404, slave 1 returns 0xCAFE_F00D after 3 wait cycles -> m_wb_dat_o=0xCAFE_F00D in ack cycle, other slaves' acks ignored.
REQ-033 NUM_SLAVES=3, access adr 0x0000_0C00 -> no slave strobe, ack+err next cycle, data 0xBADB_AD00, err_cnt_o=1.
REQ-034 TIMEOUT_CYC=4, slave 0 never acks -> ERR after 4 BUSY cycles, slave stb dropped; ack at cycle 4 in rerun -> RESP.
REQ-035 m_wb_cyc_i dropped in BUSY, then wb_rst_i mid-BUSY -> no ack, slave strobes 0 next cycle, all outputs at reset values.
REQ-036 300 unmapped accesses -> err_cnt_o saturates at 255.
